// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants: state packing, round counts, sequencer states
// and the request-legality rule used by the permutation sequencer.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam int ROUNDS_PA      = 12;
  localparam int ROUNDS_PB      = 6;
  localparam int ROUNDS_PB_128A = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perm_seq_state_e;

  // A round count is usable only if it is a real Ascon count and splits evenly into passes.
  function automatic logic nrounds_legal(input logic [3:0] n, input int rpc);
    logic known;
    known = (int'(n) == ROUNDS_PA) || (int'(n) == ROUNDS_PB) || (int'(n) == ROUNDS_PB_128A);
    return known && (rpc > 0) && ((int'(n) % rpc) == 0);
  endfunction

endpackage

// File: rtl/permutation.sv
// Combinational Ascon permutation slice: applies ROUNDS_PER_CYCLE rounds, with the
// round constants selected by the count of rounds still remaining.
module permutation
  import ascon_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 3
) (
  input  logic [3:0]   round_cnt_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned k);
    return (v >> k) | (v << (64 - k));
  endfunction

  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    ascon_state_t o;
    x0 = s.x0;
    x1 = s.x1;
    x2 = s.x2 ^ {56'd0, 4'hF - r, r};
    x3 = s.x3;
    x4 = s.x4;
    // Bitsliced 5-bit S-box.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o.x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o.x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o.x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o.x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o.x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  ascon_state_t s;

  // Round index for pass step i is 12 - remaining + i, so the last pass ends on round 11.
  always_comb begin
    s = state_i;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      s = ascon_round(s, 4'hC - round_cnt_i + 4'(i));
    end
    state_o = s;
  end

endmodule

// File: rtl/perm_sequencer.sv
// Iterative controller around one permutation slice: accepts a state and round count,
// runs the required passes and hands the result back over a valid/ready handshake.
module perm_sequencer
  import ascon_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   nrounds_i,
  input  logic [319:0] state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic         err_o,
  output logic         busy_o
);

  localparam logic [3:0] RPC4 = 4'(ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE inside {1, 2, 3, 6})) begin : g_bad_rpc
    $error("perm_sequencer: ROUNDS_PER_CYCLE must be 1, 2, 3 or 6");
  end

  perm_seq_state_e state_q;
  ascon_state_t    st_q;
  ascon_state_t    perm_d;
  logic [3:0]      rcnt_q;
  logic            err_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  permutation #(
    .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
  ) u_perm (
    .round_cnt_i(rcnt_q),
    .state_i    (st_q),
    .state_o    (perm_d)
  );

  // An illegal request still spends one cycle in RUN (state untouched) so that every
  // request reports at least one cycle after acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rcnt_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            st_q       <= state_i;
            rcnt_q     <= nrounds_i;
            err_q      <= !nrounds_legal(nrounds_i, ROUNDS_PER_CYCLE);
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (err_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            st_q   <= perm_d;
            rcnt_q <= rcnt_q - RPC4;
            if (rcnt_q == RPC4) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign state_o     = st_q;

endmodule
